// File: rtl/seg7_encode.sv
// Seven-segment pattern encoder: debounces an active-low segment bus and emits each newly
// stable pattern once as a digit code. Define SEG7_ENCODE_DP_EN to add decimal-point decode and port dp.
module seg7_encode #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] seg_in,
    input  logic       seg_valid,
    output logic [3:0] num,
    output logic       blank,
    output logic       err,
    output logic       out_valid,
    input  logic       out_ready
`ifdef SEG7_ENCODE_DP_EN
    ,
    output logic       dp
`endif
);

    localparam int unsigned PAT_W = 8;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned RES_W = 6;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] STABLE  = CNT_W'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        QUAL = 2'd1,
        PEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [PAT_W-1:0]  cand, cand_nxt;
    logic              cand_vld, cand_vld_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [PAT_W-1:0]  last, last_nxt;
    logic              last_vld, last_vld_nxt;
    logic [PAT_W-1:0]  pat, pat_nxt;
    logic [RES_W-1:0]  res_nxt;
    logic              out_valid_nxt;
    logic              dp_nxt;
    logic              accept_c;
    logic              hold_c;
    logic              qual_c;

    // Result packing: {num, blank, err}
    function automatic logic [RES_W-1:0] decode(input logic [PAT_W-1:0] p);
        case (p)
            8'hC0:   decode = {4'd0,  2'b00};
            8'hF9:   decode = {4'd1,  2'b00};
            8'hA4:   decode = {4'd2,  2'b00};
            8'hB0:   decode = {4'd3,  2'b00};
            8'h99:   decode = {4'd4,  2'b00};
            8'h92:   decode = {4'd5,  2'b00};
            8'h82:   decode = {4'd6,  2'b00};
            8'hF8:   decode = {4'd7,  2'b00};
            8'h80:   decode = {4'd8,  2'b00};
            8'h90:   decode = {4'd9,  2'b00};
            8'h00:   decode = {4'd10, 2'b00};
            8'hBE:   decode = {4'd11, 2'b00};
            8'hFF:   decode = {4'd0,  2'b10};
            default: decode = {4'd0,  2'b01};
        endcase
    endfunction

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cand      <= '0;
            cand_vld  <= 1'b0;
            cnt       <= '0;
            last      <= '0;
            last_vld  <= 1'b0;
            pat       <= '0;
            num       <= '0;
            blank     <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b0;
`ifdef SEG7_ENCODE_DP_EN
            dp        <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            cand      <= cand_nxt;
            cand_vld  <= cand_vld_nxt;
            cnt       <= cnt_nxt;
            last      <= last_nxt;
            last_vld  <= last_vld_nxt;
            pat       <= pat_nxt;
            {num, blank, err} <= res_nxt;
            out_valid <= out_valid_nxt;
`ifdef SEG7_ENCODE_DP_EN
            dp        <= dp_nxt;
`endif
        end
    end

    // Filter, emission decision and next state
    always_comb begin
        state_nxt     = state;
        cand_nxt      = cand;
        cand_vld_nxt  = cand_vld;
        cnt_nxt       = cnt;
        last_nxt      = last;
        last_vld_nxt  = last_vld;
        pat_nxt       = pat;
        res_nxt       = {num, blank, err};
        out_valid_nxt = out_valid;
        dp_nxt        = 1'b0;
`ifdef SEG7_ENCODE_DP_EN
        dp_nxt        = dp;
`endif

        if (seg_valid) begin
            if (cand_vld && seg_in == cand) begin
                cnt_nxt = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);
            end else begin
                cand_nxt     = seg_in;
                cand_vld_nxt = 1'b1;
                cnt_nxt      = CNT_W'(1);
            end
        end else begin
            cnt_nxt = '0;
        end

        accept_c = (state == PEND) && out_ready;
        hold_c   = (state == PEND) && !out_ready;
        qual_c   = (cnt_nxt >= STABLE);

        if (accept_c) begin
            last_nxt      = pat;
            last_vld_nxt  = 1'b1;
            out_valid_nxt = 1'b0;
        end

        // A qualified pattern that differs from the last accepted one loads a new result
        if (!hold_c && qual_c && (!last_vld_nxt || cand_nxt != last_nxt)) begin
            out_valid_nxt = 1'b1;
            pat_nxt       = cand_nxt;
`ifdef SEG7_ENCODE_DP_EN
            res_nxt       = decode({1'b1, cand_nxt[6:0]});
            dp_nxt        = ~cand_nxt[7];
`else
            res_nxt       = decode(cand_nxt);
`endif
        end

        if (out_valid_nxt)       state_nxt = PEND;
        else if (cnt_nxt == '0)  state_nxt = IDLE;
        else if (!qual_c)        state_nxt = QUAL;
        else                     state_nxt = DONE;
    end

`ifndef SEG7_ENCODE_DP_EN
    logic unused_dp;
    assign unused_dp = dp_nxt;
`endif

endmodule

// File: tb/tb_seg7_encode.sv
// Scoreboard bench for seg7_encode: directed segment sequences push expected results,
// a negedge monitor pops and compares on every handshake.
module tb_seg7_encode;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] seg_in;
    logic       seg_valid;
    logic [3:0] num;
    logic       blank;
    logic       err;
    logic       out_valid;
    logic       out_ready;
`ifdef SEG7_ENCODE_DP_EN
    logic       dp;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] num;
        logic       blank;
        logic       err;
        logic       dp;
    } exp_t;

    exp_t q[$];

    seg7_encode #(.STABLE_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .seg_in    (seg_in),
        .seg_valid (seg_valid),
        .num       (num),
        .blank     (blank),
        .err       (err),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef SEG7_ENCODE_DP_EN
        ,
        .dp        (dp)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic push(input logic [3:0] n, input logic b, input logic e, input logic d);
        exp_t x;
        x.num = n; x.blank = b; x.err = e; x.dp = d;
        q.push_back(x);
    endtask

    // One call drives n consecutive cycles, returning at posedge+1
    task automatic drive(input logic [7:0] p, input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            seg_in    = p;
            seg_valid = v;
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare every transfer against the scoreboard head
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                exp_t x;
                x = q.pop_front();
                check("num", int'(num), int'(x.num));
                check("blank", int'(blank), int'(x.blank));
                check("err", int'(err), int'(x.err));
`ifdef SEG7_ENCODE_DP_EN
                check("dp", int'(dp), int'(x.dp));
`endif
            end
        end
    end

    initial begin
        reset     = 1'b1;
        seg_in    = 8'h00;
        seg_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_num", int'(num), 0);
        check("rst_blank_err", int'({blank, err}), 0);

        // Latency: A4 sampled in cycles 0..3, result visible in cycle 4 only
        push(4'd2, 1'b0, 1'b0, 1'b0);
        drive(8'hA4, 1'b1, 3);
        check("lat_early", int'(out_valid), 0);
        drive(8'hA4, 1'b1, 1);
        check("lat_valid", int'(out_valid), 1);
        check("lat_num", int'(num), 2);
        drive(8'h00, 1'b0, 1);
        check("lat_drop", int'(out_valid), 0);

        // Broken run of 99 must restart the count
        push(4'd4, 1'b0, 1'b0, 1'b0);
        drive(8'h99, 1'b1, 3);
        drive(8'h99, 1'b0, 1);
        check("gap_no_emit", int'(out_valid), 0);
        drive(8'h99, 1'b1, 3);
        check("gap_still_counting", int'(out_valid), 0);
        drive(8'h99, 1'b1, 1);
        check("gap_emit", int'(out_valid), 1);
        drive(8'h00, 1'b0, 2);

        // Backpressure: held result stays stable, then exactly one transfer
        out_ready = 1'b0;
        push(4'd1, 1'b0, 1'b0, 1'b0);
        drive(8'hF9, 1'b1, 4);
        for (int i = 0; i < 10; i++) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_num", int'(num), 1);
            drive(8'hF9, 1'b1, 1);
        end
        out_ready = 1'b1;
        drive(8'hF9, 1'b1, 1);
        for (int i = 0; i < 5; i++) begin
            check("no_repeat", int'(out_valid), 0);
            drive(8'hF9, 1'b1, 1);
        end

        // Table corners: digit 0, unknown pattern, all-off
        push(4'd0, 1'b0, 1'b0, 1'b0);
        drive(8'hC0, 1'b1, 4);
        drive(8'h00, 1'b0, 1);
        push(4'd0, 1'b0, 1'b1, 1'b0);
        drive(8'h12, 1'b1, 4);
        drive(8'h00, 1'b0, 1);
        push(4'd0, 1'b1, 1'b0, 1'b0);
        drive(8'hFF, 1'b1, 4);
        drive(8'h00, 1'b0, 1);

        // Back-to-back: 92 qualifies while B0 pending, loads on acceptance edge
        out_ready = 1'b0;
        push(4'd3, 1'b0, 1'b0, 1'b0);
        drive(8'hB0, 1'b1, 4);
        push(4'd5, 1'b0, 1'b0, 1'b0);
        drive(8'h92, 1'b1, 4);
        check("b2b_first", int'(num), 3);
        out_ready = 1'b1;
        drive(8'h92, 1'b1, 1);
        check("b2b_valid", int'(out_valid), 1);
        check("b2b_second", int'(num), 5);
        drive(8'h00, 1'b0, 1);
        check("b2b_drop", int'(out_valid), 0);

        // Reset while pending discards the result; same pattern emits again
        out_ready = 1'b0;
        drive(8'hF8, 1'b1, 4);
        check("pend_num", int'(num), 7);
        reset = 1'b1;
        drive(8'hF8, 1'b1, 1);
        reset = 1'b0;
        check("rstpend_valid", int'(out_valid), 0);
        check("rstpend_num", int'(num), 0);
        out_ready = 1'b1;
        push(4'd7, 1'b0, 1'b0, 1'b0);
        drive(8'hF8, 1'b1, 4);
        drive(8'h00, 1'b0, 1);

        // Pattern 00: decimal point plus 8 with the option, code 10 without
`ifdef SEG7_ENCODE_DP_EN
        push(4'd8, 1'b0, 1'b0, 1'b1);
`else
        push(4'd10, 1'b0, 1'b0, 1'b0);
`endif
        drive(8'h00, 1'b1, 4);
        drive(8'h00, 1'b0, 1);

        // Long hold past counter saturation emits once
        push(4'd8, 1'b0, 1'b0, 1'b0);
        drive(8'h80, 1'b1, 300);
        check("sat_no_repeat", int'(out_valid), 0);
        push(4'd11, 1'b0, 1'b0, 1'b0);
        drive(8'hBE, 1'b1, 4);
        drive(8'h00, 1'b0, 3);

        check("scoreboard_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_encode.md
SEG7_ENCODE -- requirements
Module: seg7_encode

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, consecutive identical valid samples required to qualify a pattern (legal 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 seg_in  input  8  active-low segment pattern; bit 7 = decimal point, bits 6:0 = segments g..a.
REQ-005 seg_valid  input  1  seg_in is meaningful this cycle.
REQ-006 num  output  4  decoded digit code.
REQ-007 blank  output  1  qualified pattern was all-off (8'hFF).
REQ-008 err  output  1  qualified pattern not in decode table.
REQ-009 out_valid  output  1  num/blank/err hold a result.
REQ-010 out_ready  input  1  consumer accepts result when out_valid && out_ready.

Function
REQ-011 Decode table SHALL be: C0->0, F9->1, A4->2, B0->3, 99->4, 92->5, 82->6, F8->7, 80->8, 90->9, 00->10, BE->11, FF->blank=1/num=0, any other->err=1/num=0.
REQ-012 Filter: a candidate register and 8-bit saturating counter; seg_valid with seg_in==candidate increments the counter; seg_valid with a different pattern loads candidate and sets count=1; seg_valid low clears count to 0.
REQ-013 A candidate SHALL qualify when count reaches STABLE_CYCLES.
REQ-014 FSM states: IDLE (count 0), QUAL (counting, not yet qualified), PEND (out_valid=1 awaiting out_ready), DONE (qualified candidate equals last emitted pattern).
REQ-015 Qualification of a candidate differing from the last emitted pattern (or with nothing emitted since reset) SHALL load num/blank/err and raise out_valid on the same edge that count reaches STABLE_CYCLES; otherwise enter DONE.
REQ-016 Latency: out_valid high in cycle STABLE_CYCLES when the pattern is first sampled in cycle 0 and held valid.
REQ-017 While out_valid && !out_ready, num/blank/err/out_valid SHALL remain unchanged; the filter keeps running.
REQ-018 On acceptance, last-emitted register SHALL take the emitted pattern; out_valid drops next cycle unless the current candidate is already qualified and differs, in which case the new result is loaded on that edge (back-to-back, no bubble).
REQ-019 A stable pattern SHALL be emitted exactly once; re-emission requires a different qualified pattern in between.
REQ-020 Counter SHALL saturate at 255, never wrap.

Reset
REQ-021 reset SHALL force state IDLE, count=0, candidate and last-emitted invalid, num=0, blank=0, err=0, out_valid=0.
REQ-022 reset asserted during PEND SHALL discard the pending result with no handshake.
REQ-023 reset SHALL take priority over seg_valid and out_ready on the same edge.

Configuration
REQ-024 Macro SEG7_ENCODE_DP_EN compiles in decimal-point decoding and output port dp (1 bit).
REQ-025 With SEG7_ENCODE_DP_EN: bits 6:0 decoded using the table with bit 7 forced 1; dp=~seg_in[7] of the qualified pattern; 8'h00 yields num=8, dp=1 (code 10 never produced); 8'h7F yields blank=1, dp=1.
REQ-026 Without SEG7_ENCODE_DP_EN: no dp port; exact 8-bit table of REQ-011 applies.

Verification
REQ-027 STABLE_CYCLES=4, seg_in=A4 valid 4 cycles, out_ready=1 -> out_valid one cycle in cycle 4, num=2, blank=0, err=0.
REQ-028 seg_in=99 for 3 cycles, seg_valid low 1 cycle, 99 for 4 cycles -> single result num=4 only after the second run.
REQ-029 out_ready=0, qualify F9 then hold 10 cycles -> out_valid, num=1 stable; raise out_ready -> one transfer, no repeat while F9 persists.
REQ-030 Qualify C0, accept, then 12 for 4 cycles -> err=1, num=0; then FF for 4 cycles -> blank=1, num=0.
REQ-031 reset during PEND with num=7 -> next cycle out_valid=0, num=0; same F8 re-qualified -> emitted again.
REQ-032 With SEG7_ENCODE_DP_EN, seg_in=00 for 4 cycles -> num=8, dp=1; without macro -> num=10.
